// File: rtl/execute_stage_if.sv
// execute_stage_if: E-stage operand/control inputs, EX/MEM register outputs and the stall request.
`default_nettype none

`ifndef WORD
`define WORD 32
`endif
`ifndef REG_SIZE
`define REG_SIZE 5
`endif

interface execute_stage_if;
    logic                 en;
    logic                 flushE;
    logic [`WORD-1:0]     srcAE;
    logic [`WORD-1:0]     srcBE;
    logic [`WORD-1:0]     writeDataE;
    logic [`WORD-1:0]     pcE;
    logic [3:0]           aluControlE;
    logic [`REG_SIZE-1:0] writeRegE;
    logic                 regWriteE;
    logic                 memWriteE;
    logic                 mem2regE;
    logic                 finishE;
    logic                 validE;

    logic [`WORD-1:0]     ALUResultM;
    logic [`WORD-1:0]     writeDataM;
    logic [`WORD-1:0]     pcM;
    logic [`REG_SIZE-1:0] writeRegM;
    logic                 regWriteM;
    logic                 memWriteM;
    logic                 mem2regM;
    logic                 finishM;
    logic                 validM;
    logic                 busyE;

    modport master (
        output en, flushE, srcAE, srcBE, writeDataE, pcE, aluControlE, writeRegE,
               regWriteE, memWriteE, mem2regE, finishE, validE,
        input  ALUResultM, writeDataM, pcM, writeRegM, regWriteM, memWriteM,
               mem2regM, finishM, validM, busyE
    );

    modport slave (
        input  en, flushE, srcAE, srcBE, writeDataE, pcE, aluControlE, writeRegE,
               regWriteE, memWriteE, mem2regE, finishE, validE,
        output ALUResultM, writeDataM, pcM, writeRegM, regWriteM, memWriteM,
               mem2regM, finishM, validM, busyE
    );
endinterface

`default_nettype wire

// File: rtl/execute_stage.sv
// execute_stage: single-cycle ALU plus 32-iteration restoring divider feeding the EX/MEM register.
`default_nettype none

`ifndef WORD
`define WORD 32
`endif
`ifndef REG_SIZE
`define REG_SIZE 5
`endif

module execute_stage (
    input  wire logic        clk,
    input  wire logic        reset,
    execute_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [5:0]       r_count;
    logic [`WORD-1:0] r_quo;
    logic [`WORD-1:0] r_rem;
    logic [`WORD-1:0] r_divisor;

    logic             w_is_div;
    logic             w_busy;
    logic             w_start;
    logic             w_step;
    logic [`WORD:0]   w_shift;
    logic [`WORD:0]   w_diff;
    logic             w_fits;
    logic [`WORD-1:0] w_alu;
    logic [`WORD-1:0] w_result;

    assign w_is_div = (bus.aluControlE == 4'd12) || (bus.aluControlE == 4'd13);
    assign w_busy   = bus.validE & w_is_div & (r_state != S_DONE) & ~bus.flushE;
    assign bus.busyE = w_busy;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.validE & w_is_div & ~bus.flushE) begin
                    w_state_next = S_DIV;
                    w_start      = 1'b1;
                end
            end
            S_DIV: begin
                w_step = 1'b1;
                if (r_count == 6'd31) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (bus.en) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (bus.flushE & bus.en) begin
            w_state_next = S_IDLE;
            w_start      = 1'b0;
            w_step       = 1'b0;
        end
    end

    // Partial remainder shifted left with the next dividend bit; a zero divisor always fits,
    // which naturally yields an all-ones quotient and the dividend as remainder.
    assign w_shift = {r_rem, r_quo[`WORD-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};
    assign w_fits  = ~w_diff[`WORD];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 6'd0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (w_start) begin
            r_count   <= 6'd0;
            r_quo     <= bus.srcAE;
            r_rem     <= '0;
            r_divisor <= bus.srcBE;
        end else if (w_step) begin
            r_count <= r_count + 6'd1;
            r_rem   <= w_fits ? w_diff[`WORD-1:0] : w_shift[`WORD-1:0];
            r_quo   <= {r_quo[`WORD-2:0], w_fits};
        end
    end

    always_comb begin
        w_alu = '0;
        case (bus.aluControlE)
            4'd0:  w_alu = bus.srcAE + bus.srcBE;
            4'd1:  w_alu = bus.srcAE - bus.srcBE;
            4'd2:  w_alu = bus.srcAE & bus.srcBE;
            4'd3:  w_alu = bus.srcAE | bus.srcBE;
            4'd4:  w_alu = bus.srcAE ^ bus.srcBE;
            4'd5:  w_alu = {{(`WORD-1){1'b0}}, $signed(bus.srcAE) < $signed(bus.srcBE)};
            4'd6:  w_alu = {{(`WORD-1){1'b0}}, bus.srcAE < bus.srcBE};
            4'd7:  w_alu = bus.srcAE << bus.srcBE[4:0];
            4'd8:  w_alu = bus.srcAE >> bus.srcBE[4:0];
            4'd9:  w_alu = $unsigned($signed(bus.srcAE) >>> bus.srcBE[4:0]);
            4'd10: w_alu = bus.srcBE;
            4'd11: w_alu = bus.srcAE * bus.srcBE;
            default: w_alu = '0;
        endcase
    end

    assign w_result = w_is_div ? ((bus.aluControlE == 4'd12) ? r_quo : r_rem) : w_alu;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ALUResultM <= '0;
            bus.writeDataM <= '0;
            bus.pcM        <= '0;
            bus.writeRegM  <= '0;
            bus.regWriteM  <= 1'b0;
            bus.memWriteM  <= 1'b0;
            bus.mem2regM   <= 1'b0;
            bus.finishM    <= 1'b0;
            bus.validM     <= 1'b0;
        end else if (bus.en) begin
            if (bus.flushE | w_busy) begin
                bus.ALUResultM <= '0;
                bus.writeDataM <= '0;
                bus.pcM        <= '0;
                bus.writeRegM  <= '0;
                bus.regWriteM  <= 1'b0;
                bus.memWriteM  <= 1'b0;
                bus.mem2regM   <= 1'b0;
                bus.finishM    <= 1'b0;
                bus.validM     <= 1'b0;
            end else begin
                bus.ALUResultM <= w_result;
                bus.writeDataM <= bus.writeDataE;
                bus.pcM        <= bus.pcE;
                bus.writeRegM  <= bus.writeRegE;
                bus.regWriteM  <= bus.regWriteE;
                bus.memWriteM  <= bus.memWriteE;
                bus.mem2regM   <= bus.mem2regE;
                bus.finishM    <= bus.finishE;
                bus.validM     <= bus.validE;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vector table, corner-case sequences and random ops against a reference model.
`default_nettype none

module tb_execute_stage;
    logic clk = 1'b0;
    logic reset;
    execute_stage_if bus();

    execute_stage dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [79:0] exp_meta;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [19];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned prod;
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd10: return b;
            4'd11: begin prod = longint'(a) * longint'(b); return prod[31:0]; end
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [79:0] m_fields();
        return {6'd0, bus.validM, bus.regWriteM, bus.memWriteM, bus.mem2regM, bus.finishM,
                bus.writeRegM, bus.pcM, bus.writeDataM};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.en          = 1'b1;
        bus.flushE      = 1'b0;
        bus.validE      = 1'b1;
        bus.aluControlE = op;
        bus.srcAE       = a;
        bus.srcBE       = b;
        bus.pcE         = $urandom;
        bus.writeDataE  = $urandom;
        bus.writeRegE   = 5'($urandom);
        bus.regWriteE   = 1'($urandom);
        bus.memWriteE   = 1'($urandom);
        bus.mem2regE    = 1'($urandom);
        bus.finishE     = 1'($urandom);
        exp_meta = {6'd0, 1'b1, bus.regWriteE, bus.memWriteE, bus.mem2regE, bus.finishE,
                    bus.writeRegE, bus.pcE, bus.writeDataE};
    endtask

    task automatic run_instr(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        int  n;
        bit  is_div;
        bit  bubble_bad;
        is_div = (op == 4'd12) || (op == 4'd13);
        drive(op, a, b);
        #1;
        n = 0;
        bubble_bad = 1'b0;
        while (bus.busyE === 1'b1 && n < 40) begin
            step();
            n++;
            if (bus.validM !== 1'b0) bubble_bad = 1'b1;
        end
        check({name, "_busy_cycles"}, 80'(n), is_div ? 80'd33 : 80'd0);
        if (is_div) check({name, "_bubbles"}, 80'(bubble_bad), 80'd0);
        step();
        check({name, "_result"}, 80'(bus.ALUResultM), 80'(exp));
        check({name, "_fields"}, m_fields(), exp_meta);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  32'd5,          32'd7,          32'd12};
        vecs[1]  = '{4'd1,  32'd5,          32'd7,          32'hFFFF_FFFE};
        vecs[2]  = '{4'd2,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
        vecs[3]  = '{4'd3,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0};
        vecs[4]  = '{4'd4,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0};
        vecs[5]  = '{4'd5,  32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[6]  = '{4'd6,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[7]  = '{4'd7,  32'd1,          32'h0000_003F,  32'h8000_0000};
        vecs[8]  = '{4'd8,  32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[9]  = '{4'd9,  32'h8000_0000,  32'd4,          32'hF800_0000};
        vecs[10] = '{4'd10, 32'd99,         32'h0000_1234,  32'h0000_1234};
        vecs[11] = '{4'd11, 32'h0001_0000,  32'h0001_0000,  32'd0};
        vecs[12] = '{4'd11, 32'd7,          32'd6,          32'd42};
        vecs[13] = '{4'd14, 32'd7,          32'd6,          32'd0};
        vecs[14] = '{4'd15, 32'd7,          32'd6,          32'd0};
        vecs[15] = '{4'd12, 32'd100,        32'd7,          32'd14};
        vecs[16] = '{4'd13, 32'd100,        32'd7,          32'd2};
        vecs[17] = '{4'd13, 32'd100,        32'd0,          32'd100};
        vecs[18] = '{4'd12, 32'd100,        32'd0,          32'hFFFF_FFFF};

        reset = 1'b1;
        drive(4'd0, 32'd1, 32'd2);
        step();
        step();
        check("reset_result", 80'(bus.ALUResultM), 80'd0);
        check("reset_fields", m_fields(), 80'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++)
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Result parked in DONE while the pipeline is stalled externally.
        begin
            int n;
            drive(4'd12, 32'hFFFF_FFFF, 32'd3);
            #1;
            n = 0;
            while (bus.busyE === 1'b1 && n < 40) begin step(); n++; end
            check("hold_busy_cycles", 80'(n), 80'd33);
            bus.en = 1'b0;
            repeat (10) step();
            check("hold_busy", 80'(bus.busyE), 80'd0);
            check("hold_validM", 80'(bus.validM), 80'd0);
            bus.en = 1'b1;
            step();
            check("hold_result", 80'(bus.ALUResultM), 80'h5555_5555);
            check("hold_validM_after", 80'(bus.validM), 80'd1);
        end

        // Flush on the tenth cycle of a division.
        drive(4'd12, 32'd1000, 32'd3);
        repeat (9) step();
        bus.flushE = 1'b1;
        #1;
        check("flush_busy", 80'(bus.busyE), 80'd0);
        step();
        check("flush_bubble", m_fields(), 80'd0);
        check("flush_result", 80'(bus.ALUResultM), 80'd0);
        run_instr("post_flush_add", 4'd0, 32'd20, 32'd22, 32'd42);
        run_instr("post_flush_div", 4'd12, 32'd1000, 32'd3, 32'd333);

        // Reset in the middle of a division.
        drive(4'd13, 32'd12345, 32'd77);
        repeat (5) step();
        reset = 1'b1;
        step();
        check("midreset_result", 80'(bus.ALUResultM), 80'd0);
        check("midreset_fields", m_fields(), 80'd0);
        reset = 1'b0;
        run_instr("post_reset_sra", 4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_instr("post_reset_rem", 4'd13, 32'd12345, 32'd77, ref_alu(4'd13, 32'd12345, 32'd77));

        for (int i = 0; i < 50; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = ($urandom_range(0, 4) == 0) ? 4'(12 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            run_instr($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_alu(op, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters: none. Widths SHALL come from the global macros: `WORD = 32 and `REG_SIZE = 5.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 en  in  1  global pipeline enable; low means the EX/MEM register holds.
REQ-005 flushE  in  1  kill the instruction currently in E.
REQ-006 srcAE, srcBE  in  `WORD  ALU operands, already forwarded upstream.
REQ-007 writeDataE  in  `WORD  store data.
REQ-008 pcE  in  `WORD  instruction PC.
REQ-009 aluControlE  in  4  operation select.
REQ-010 writeRegE  in  `REG_SIZE  destination register.
REQ-011 regWriteE, memWriteE, mem2regE, finishE, validE  in  1 each  control bits for the instruction in E.
REQ-012 ALUResultM, writeDataM, pcM  out  `WORD  EX/MEM register outputs.
REQ-013 writeRegM  out  `REG_SIZE  EX/MEM register output.
REQ-014 regWriteM, memWriteM, mem2regM, finishM, validM  out  1 each  EX/MEM register outputs.
REQ-015 busyE  out  1  combinational stall request to the hazard unit.

Function
REQ-016 Single-cycle ops by aluControlE SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 pass B, 11 MUL (low 32 bits of the product).
- Shift amount SHALL be srcBE[4:0].
- Codes 14 and 15 SHALL produce 0.
REQ-017 Ops 12 DIVU and 13 REMU SHALL use an iterative unsigned restoring divider, one quotient bit per cycle.
REQ-018 Divider FSM states and transitions:
- IDLE -> DIV when validE & div op & ~flushE; latch both operands and clear the 6-bit counter.
- DIV -> DONE after exactly 32 iterations.
- DONE -> IDLE on the first cycle with en=1.
REQ-019 busyE SHALL equal validE & div op & (state != DONE).
- A division occupies E for 34 cycles.
- busyE is high for the first 33 of them.
REQ-020 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend, with no early exit.
REQ-021 While busyE=1 and en=1, the EX/MEM register SHALL load a bubble: all control bits 0 and all data fields 0.
REQ-022 Otherwise, when en=1, it SHALL load the E fields, with ALUResultM equal to the single-cycle result or the divider result.
REQ-023 flushE with en=1 SHALL:
- return the FSM to IDLE;
- load a bubble into EX/MEM;
- take priority over an in-flight division and over busyE, which SHALL be 0 during flushE.
REQ-024 With en=0, the EX/MEM register SHALL hold.
- The divider SHALL continue iterating.
- The divider SHALL remain in DONE until en=1.
REQ-025 The FSM SHALL ignore changes on srcAE/srcBE after the operands are latched.

Reset
REQ-026 reset=1 SHALL clear every EX/MEM output to 0, force the FSM to IDLE, and clear the counter and divider registers. reset SHALL override en and flushE.
REQ-027 reset mid-division SHALL abandon the operation. busyE SHALL then follow REQ-019 from IDLE on the next cycle.

Verification
REQ-028 ADD with srcA=5, srcB=7, en=1 -> next edge: ALUResultM=12, validM=1, busyE never 1.
REQ-029 DIVU 100/7 -> busyE high 33 cycles; ALUResultM=14 on the 34th edge; bubbles (validM=0) before that.
REQ-030 REMU 100/0 -> ALUResultM=100; DIVU 100/0 -> ALUResultM=0xFFFFFFFF; both take 34 cycles.
REQ-031 DIVU 0xFFFFFFFF/3 with en=0 held for 10 cycles in DONE -> result 0x55555555 is held and captured on the first en=1 edge.
REQ-032 flushE asserted on cycle 10 of a division -> bubble in M, FSM back in IDLE, busyE=0; a following ADD completes in 1 cycle.
REQ-033 reset asserted mid-division -> all outputs 0 next edge, FSM IDLE; a following SRA 0x80000000 by 4 -> 0xF8000000.
